button_debouncer: RTL and testbench

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

---
 rtl/button_debouncer.sv | 134 +++++++++++++
 tb/tb_button_debouncer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - synchronized push-button debouncer with press/release pulses; long-press pulse enabled by macro LONG_PRESS_EN
module button_debouncer #(
  parameter logic [31:0] DEBOUNCE_CYCLES = 32'd2000000,
  parameter logic [31:0] LONG_CYCLES     = 32'd100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  localparam logic [31:0] DEB_LAST = DEBOUNCE_CYCLES - 32'd1;

  state_t      state;
  logic        s1;
  logic        s2;
  logic [31:0] cnt;
  logic        press_done;
  logic        release_done;

  // Two-flop synchronizer for the asynchronous button level
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= button;
      s2 <= s1;
    end
  end

  // Debounce-complete conditions, shared by the FSM and the long-press counter
  always_comb begin
    press_done   = (state == PRESS_WAIT)   &&  s2 && (cnt == DEB_LAST);
    release_done = (state == RELEASE_WAIT) && !s2 && (cnt == DEB_LAST);
  end

  // Debounce FSM with registered level and one-cycle edge pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 32'd0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      case (state)
        IDLE: begin
          if (s2) begin
            state <= PRESS_WAIT;
            cnt   <= 32'd1;
          end
        end
        PRESS_WAIT: begin
          if (!s2) begin
            state <= IDLE;
            cnt   <= 32'd0;
          end else if (press_done) begin
            state     <= PRESSED;
            btn_level <= 1'b1;
            btn_press <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        PRESSED: begin
          if (!s2) begin
            state <= RELEASE_WAIT;
            cnt   <= 32'd1;
          end
        end
        RELEASE_WAIT: begin
          if (s2) begin
            state <= PRESSED;
          end else if (release_done) begin
            state       <= IDLE;
            btn_level   <= 1'b0;
            btn_release <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 32'd0;
        end
      endcase
    end
  end

`ifdef LONG_PRESS_EN
  logic [31:0] long_cnt;
  logic        long_fired;

  // Hold-time counter: restarts on each accepted press, fires once, saturates
  always_ff @(posedge clk) begin
    if (rst) begin
      long_cnt   <= 32'd0;
      long_fired <= 1'b0;
      btn_long   <= 1'b0;
    end else begin
      btn_long <= 1'b0;
      if (press_done) begin
        long_cnt   <= 32'd0;
        long_fired <= 1'b0;
      end else if (state == PRESSED || state == RELEASE_WAIT) begin
        if (long_cnt != 32'hFFFF_FFFF) begin
          long_cnt <= long_cnt + 32'd1;
        end
        // The release pulse wins on a coincident edge so pulses never overlap
        if (!long_fired && !release_done && long_cnt == LONG_CYCLES - 32'd1) begin
          btn_long   <= 1'b1;
          long_fired <= 1'b1;
        end
      end
    end
  end
`else
  assign btn_long = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - directed self-checking bench for button_debouncer
module tb_button_debouncer;

  localparam logic [31:0] DEB  = 32'd4;
  localparam logic [31:0] LONG = 32'd10;
`ifdef LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  logic button;
  logic btn_level;
  logic btn_press;
  logic btn_release;
  logic btn_long;

  int checks;
  int failures;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LONG)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .button     (button),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic lvl, input logic prs,
                         input logic rel, input logic lng);
    chk({tag, ".level"},   btn_level,   lvl);
    chk({tag, ".press"},   btn_press,   prs);
    chk({tag, ".release"}, btn_release, rel);
    chk({tag, ".long"},    btn_long,    lng);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    button   = 1'b0;

    // Reset state
    tick();
    tick();
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_all("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Clean press: first high sample at edge 0, press pulse after edge 5
    button = 1'b1;
    for (int e = 0; e <= 5; e++) begin
      tick();
      chk_all($sformatf("press_e%0d", e), (e >= 5), (e == 5), 1'b0, 1'b0);
    end

    // Hold 30 edges past entry P=5: single long pulse after edge 15 when enabled
    for (int e = 6; e <= 35; e++) begin
      tick();
      chk_all($sformatf("hold_e%0d", e), 1'b1, 1'b0, 1'b0, LONG_EN && (e == 15));
    end

    // Release glitch: two low samples then high again
    button = 1'b0;
    tick();
    tick();
    chk_all("glitch_low", 1'b1, 1'b0, 1'b0, 1'b0);
    button = 1'b1;
    for (int e = 2; e <= 9; e++) begin
      tick();
      chk_all($sformatf("glitch_e%0d", e), 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // Clean release: first low sample at edge 0, release pulse after edge 5
    button = 1'b0;
    for (int e = 0; e <= 7; e++) begin
      tick();
      chk_all($sformatf("release_e%0d", e), (e < 5), 1'b0, (e == 5), 1'b0);
    end

    // Bounce reject: high for edges 0-2, then low
    button = 1'b1;
    for (int e = 0; e <= 9; e++) begin
      tick();
      if (e == 2) button = 1'b0;
      chk_all($sformatf("bounce_e%0d", e), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Reset while in PRESS_WAIT
    button = 1'b1;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk_all("rst_pw", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Button still held at reset release: debounced from scratch
    for (int e = 0; e <= 6; e++) begin
      tick();
      chk_all($sformatf("held_e%0d", e), (e >= 5), (e == 5), 1'b0, 1'b0);
    end

    // Reset while PRESSED: level drops, no release or long pulse follows
    rst = 1'b1;
    tick();
    chk_all("rst_pr", 1'b0, 1'b0, 1'b0, 1'b0);
    rst    = 1'b0;
    button = 1'b0;
    for (int e = 0; e <= 14; e++) begin
      tick();
      chk_all($sformatf("post_rst_e%0d", e), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Re-press after reset is detected with normal latency
    button = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      tick();
      chk_all($sformatf("repress_e%0d", e), (e >= 5), (e == 5), 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
